// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Sign helpers work on a fixed wide vector; callers zero-extend in and truncate out.
package div_pkg;

  localparam int DIV_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic logic [DIV_MAX_W-1:0] neg_if(input logic [DIV_MAX_W-1:0] x,
                                                  input logic                 en);
    logic [DIV_MAX_W-1:0] res;
    if (en) begin
      res = ~x + DIV_MAX_W'(1'b1);
    end else begin
      res = x;
    end
    return res;
  endfunction

  // The low WIDTH bits of the wide negation equal the WIDTH-bit two's complement.
  function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] x,
                                                   input logic                 is_neg);
    return neg_if(x, is_neg);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between the ALU and the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] r;
  logic             ovf;
  logic             dz;

  modport master (
    output in_valid, signed_mode, a, b, out_ready,
    input  in_ready, out_valid, quo, r, ovf, dz
  );

  modport slave (
    input  in_valid, signed_mode, a, b, out_ready,
    output in_ready, out_valid, quo, r, ovf, dz
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // rem < dvs always holds, so the WIDTH+1-bit difference sign is exact.
  always_comb begin
    shifted_s = {rem, dvd_bit};
    diff_s    = shifted_s - {1'b0, dvs};
    q_bit     = ~diff_s[WIDTH];
    if (q_bit) begin
      rem_nxt = diff_s[WIDTH-1:0];
    end else begin
      rem_nxt = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, with valid/ready on both sides.
// Exceptional operands are preloaded as the raw result and finish through FIX.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

  div_state_e       state_r;
  div_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic             neg_quo_r;
  logic             neg_rem_r;
  logic             dz_pend_r;
  logic             ovf_pend_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] r_r;
  logic             dz_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             b_zero_s;
  logic             ovf_case_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] rem_step_s;
  logic             q_bit_s;

  assign accept_s   = bus.in_valid & in_ready_r;
  assign b_zero_s   = (bus.b == {WIDTH{1'b0}});
  assign ovf_case_s = bus.signed_mode & (bus.a == MIN_VAL) & (bus.b == ONES_VAL);
  assign a_neg_s    = bus.signed_mode & bus.a[WIDTH-1];
  assign b_neg_s    = bus.signed_mode & bus.b[WIDTH-1];
  assign a_abs_s    = WIDTH'(abs_val(DIV_MAX_W'(bus.a), a_neg_s));
  assign b_abs_s    = WIDTH'(abs_val(DIV_MAX_W'(bus.b), b_neg_s));
  assign quo_fix_s  = WIDTH'(neg_if(DIV_MAX_W'(dvd_r), neg_quo_r));
  assign rem_fix_s  = WIDTH'(neg_if(DIV_MAX_W'(rem_r), neg_rem_r));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .dvd_bit (dvd_r[WIDTH-1]),
    .dvs     (dvs_r),
    .rem_nxt (rem_step_s),
    .q_bit   (q_bit_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (b_zero_s || ovf_case_s) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:  state_nxt_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      dvd_r      <= {WIDTH{1'b0}};
      dvs_r      <= {WIDTH{1'b0}};
      neg_quo_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      dz_pend_r  <= 1'b0;
      ovf_pend_r <= 1'b0;
      quo_r      <= {WIDTH{1'b0}};
      r_r        <= {WIDTH{1'b0}};
      dz_r       <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r      <= CNT_LAST;
            dz_pend_r  <= b_zero_s;
            ovf_pend_r <= ovf_case_s & ~b_zero_s;
            if (b_zero_s) begin
              dvd_r     <= ONES_VAL;
              rem_r     <= bus.a;
              neg_quo_r <= 1'b0;
              neg_rem_r <= 1'b0;
            end else if (ovf_case_s) begin
              dvd_r     <= MIN_VAL;
              rem_r     <= {WIDTH{1'b0}};
              neg_quo_r <= 1'b0;
              neg_rem_r <= 1'b0;
            end else begin
              dvd_r     <= a_abs_s;
              dvs_r     <= b_abs_s;
              rem_r     <= {WIDTH{1'b0}};
              neg_quo_r <= a_neg_s ^ b_neg_s;
              neg_rem_r <= a_neg_s;
            end
          end
        end
        CALC: begin
          rem_r <= rem_step_s;
          dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
          cnt_r <= cnt_r - CNT_ONE;
        end
        FIX: begin
          quo_r <= quo_fix_s;
          r_r   <= rem_fix_s;
          dz_r  <= dz_pend_r;
          ovf_r <= ovf_pend_r;
        end
        DONE: begin
          quo_r <= quo_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quo       = quo_r;
  assign bus.r         = r_r;
  assign bus.ovf       = ovf_r;
  assign bus.dz        = dz_r;

endmodule
